// File: rtl/m_circlequeue_gen_pkg.sv
// Shared sizing helpers and the per-cycle operation encoding for the circular queue.
// Sizing helpers are reused by the LED / 7-segment feeder blocks.
package m_circlequeue_gen_pkg;

  function automatic int cq_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cq_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bit order is {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } cq_op_e;

endpackage

// File: rtl/m_cq_ram.sv
// DEPTH x DATA_W simple dual-port array: synchronous write, registered read.
// Only the read register is reset; the array contents are left untouched.
module m_cq_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read and a write to the same slot return the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/m_circlequeue_gen.sv
// Parametrised circular queue with occupancy count, registered read strobe and level flags.
// Optional sticky overflow/underflow flags when CQ_ERRFLAG_EN is defined.
module m_circlequeue_gen
  import m_circlequeue_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_rd,
  output logic [DATA_W-1:0]          o_rdata,
  output logic                       o_rvalid,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_afull,
  output logic                       o_aempty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef CQ_ERRFLAG_EN
  ,
  output logic                       o_ovf,
  output logic                       o_udf,
  input  logic                       i_errclr
`endif
);

  localparam int ADDR_W = cq_addr_w(DEPTH);
  localparam int CNT_W  = cq_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_LVL);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("m_circlequeue_gen: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rvalid_q, empty_q, full_q, afull_q, aempty_q;
  logic              rd_acc, wr_acc;
  cq_op_e            op;

  // A full queue still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = i_rd & ~empty_q;
  assign wr_acc = i_wr & (~full_q | rd_acc);
  assign op     = cq_op_e'({wr_acc, rd_acc});

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + PTR_ONE;
    if (rd_acc) rptr_d = rptr_q + PTR_ONE;
    case (op)
      OP_WR:   count_d = count_q + CNT_ONE;
      OP_RD:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Flags come from the next-state count so they line up with o_count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= (AF_LVL == 0);
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rvalid_q <= rd_acc;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_MAX);
      afull_q  <= (count_d >= AF_C);
      aempty_q <= (count_d <= AE_C);
    end
  end

  m_cq_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (i_wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (o_rdata)
  );

  assign o_rvalid = rvalid_q;
  assign o_full   = full_q;
  assign o_empty  = empty_q;
  assign o_afull  = afull_q;
  assign o_aempty = aempty_q;
  assign o_count  = count_q;

`ifdef CQ_ERRFLAG_EN
  logic ovf_q, udf_q;

  // A new error in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (i_wr & ~wr_acc) | (ovf_q & ~i_errclr);
      udf_q <= (i_rd & empty_q) | (udf_q & ~i_errclr);
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_m_circlequeue_gen.sv
// Self-checking bench for m_circlequeue_gen (DATA_W=8, DEPTH=8, AF_LVL=6, AE_LVL=1).
// Error-flag checks are active when CQ_ERRFLAG_EN is defined for the build.
module tb_m_circlequeue_gen;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AF = 6;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr = 1'b0;
  logic [DW-1:0] i_wdata = '0;
  logic          i_rd = 1'b0;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid, o_full, o_empty, o_afull, o_aempty;
  logic [3:0]    o_count;
`ifdef CQ_ERRFLAG_EN
  logic          o_ovf, o_udf;
  logic          i_errclr = 1'b0;
`endif

  m_circlequeue_gen #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr     (i_wr),
    .i_wdata  (i_wdata),
    .i_rd     (i_rd),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_afull  (o_afull),
    .o_aempty (o_aempty),
    .o_count  (o_count)
`ifdef CQ_ERRFLAG_EN
    ,
    .o_ovf    (o_ovf),
    .o_udf    (o_udf),
    .i_errclr (i_errclr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO queue plus the observable registers.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_rvalid = 1'b0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    chk("count",  32'(o_count), n);
    chk("empty",  32'(o_empty), 32'(n == 0));
    chk("full",   32'(o_full), 32'(n == DP));
    chk("afull",  32'(o_afull), 32'(n >= AF));
    chk("aempty", 32'(o_aempty), 32'(n <= AE));
    chk("rvalid", 32'(o_rvalid), 32'(exp_rvalid));
    chk("rdata",  32'(o_rdata), 32'(exp_rdata));
`ifdef CQ_ERRFLAG_EN
    chk("ovf",    32'(o_ovf), 32'(exp_ovf));
    chk("udf",    32'(o_udf), 32'(exp_udf));
`endif
  endtask

  // One clock cycle: drive inputs, clock, advance the model, compare.
  task automatic step(input logic rst, input logic wr, input logic [DW-1:0] wd,
                      input logic rd, input logic clr);
    logic ra, wa, was_empty;
    rst_n   = ~rst;
    i_wr    = wr;
    i_wdata = wd;
    i_rd    = rd;
`ifdef CQ_ERRFLAG_EN
    i_errclr = clr;
`endif
    @(posedge clk);
    #1;
    step_no++;
    if (rst) begin
      model_q.delete();
      exp_rdata  = '0;
      exp_rvalid = 1'b0;
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
    end else begin
      was_empty  = (model_q.size() == 0);
      ra         = rd && !was_empty;
      wa         = wr && (model_q.size() < DP || ra);
      exp_rvalid = ra;
      if (ra) exp_rdata = model_q.pop_front();
      if (wa) model_q.push_back(wd);
      exp_ovf = (wr && !wa) || (exp_ovf && !clr);
      exp_udf = (rd && was_empty) || (exp_udf && !clr);
    end
    $display("step %0d rst=%0b wr=%0b wd=%02h rd=%0b clr=%0b -> count=%0d rvalid=%0b rdata=%02h",
             step_no, rst, wr, wd, rd, clr, o_count, o_rvalid, o_rdata);
    check_all();
  endtask

  initial begin
    // Reset held for two clocks
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);

    // Fill 0x10..0x17, then an overflowing write
    for (int i = 0; i < DP; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
    step(0, 1, 8'hFF, 0, 0);

    // Drain in order, then an underflowing read
    for (int i = 0; i < DP; i++) step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);

    // Pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    end
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0);

    // Full with simultaneous read and write
    for (int i = 0; i < DP; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
    step(0, 1, 8'h55, 1, 0);
    for (int i = 0; i < DP; i++) step(0, 0, 8'h00, 1, 0);

    // Empty with simultaneous read and write: no bypass
    step(0, 1, 8'h77, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 1);

    // Reset mid-operation together with a read
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hC0 + i), 0, 0);
    step(1, 0, 8'h00, 1, 0);
    step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);

    // Randomised traffic with occasional clears and resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 35)),
           8'($urandom),
           ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 35 : 70)),
           ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
